// File: rtl/mii_tx_sink.sv
// MII transmit-side sink: strips preamble/SFD/FCS, packs nibbles into bytes,
// checks the CRC32 residue and emits each frame as an 8-bit AXI stream.
module mii_tx_sink #(
  parameter int MIN_PREAMBLE_NIBBLES = 2,
  parameter int MAX_FRAME_LENGTH     = 1518
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] mii_txd,
  input  logic       mii_tx_en,
  input  logic       mii_tx_er,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  input  logic       cfg_enable,
  output logic       error_bad_frame,
  output logic       error_bad_fcs,
  output logic       error_preamble
);

  localparam logic [3:0]  MIN_PRE = 4'(MIN_PREAMBLE_NIBBLES);
  localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_LENGTH);
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DISCARD} state_t;

  state_t         state, state_nxt;
  logic           tx_en_prev;
  logic [3:0]     pre_cnt;
  logic           nib_odd;
  logic [3:0]     nib_lo;
  logic [31:0]    crc;
  logic [15:0]    byte_cnt;
  logic           err;
  logic [3:0][7:0] dl;
  logic [2:0]     dl_cnt;
  logic [7:0]     pend;
  logic           pend_vld;

  logic           sfd_ok, pre_err, byte_done, eof;
  logic [7:0]     byte_in;
  logic           crc_bad, bad;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign byte_in = {mii_txd, nib_lo};
  assign crc_bad = (crc != CRC_RESIDUE);
  assign bad     = err | nib_odd | (byte_cnt > MAX_LEN) | crc_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sfd_ok    = 1'b0;
    pre_err   = 1'b0;
    byte_done = 1'b0;
    eof       = 1'b0;
    case (state)
      IDLE:
        if (mii_tx_en && !tx_en_prev) state_nxt = cfg_enable ? PREAMBLE : DISCARD;
      PREAMBLE:
        if (!mii_tx_en) begin
          pre_err   = 1'b1;
          state_nxt = IDLE;
        end else if (mii_tx_er) begin
          pre_err   = 1'b1;
          state_nxt = DISCARD;
        end else if (mii_txd == 4'h5) begin
          state_nxt = PREAMBLE;
        end else if (mii_txd == 4'hD && pre_cnt >= MIN_PRE) begin
          sfd_ok    = 1'b1;
          state_nxt = PAYLOAD;
        end else begin
          pre_err   = 1'b1;
          state_nxt = DISCARD;
        end
      PAYLOAD:
        if (!mii_tx_en) begin
          eof       = 1'b1;
          state_nxt = IDLE;
        end else begin
          byte_done = nib_odd;
        end
      DISCARD:
        if (!mii_tx_en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_en_prev      <= 1'b1;  // a frame already in flight at reset release is skipped
      pre_cnt         <= '0;
      nib_odd         <= 1'b0;
      nib_lo          <= '0;
      crc             <= 32'hFFFFFFFF;
      byte_cnt        <= '0;
      err             <= 1'b0;
      dl              <= '0;
      dl_cnt          <= '0;
      pend            <= '0;
      pend_vld        <= 1'b0;
      m_axis_tdata    <= '0;
      m_axis_tvalid   <= 1'b0;
      m_axis_tlast    <= 1'b0;
      m_axis_tuser    <= 1'b0;
      error_bad_frame <= 1'b0;
      error_bad_fcs   <= 1'b0;
      error_preamble  <= 1'b0;
    end else begin
      tx_en_prev      <= mii_tx_en;
      m_axis_tvalid   <= 1'b0;
      m_axis_tlast    <= 1'b0;
      m_axis_tuser    <= 1'b0;
      error_bad_frame <= 1'b0;
      error_bad_fcs   <= 1'b0;
      error_preamble  <= pre_err;

      if (state == IDLE && state_nxt == PREAMBLE)
        pre_cnt <= (mii_txd == 4'h5) ? 4'd1 : 4'd0;
      else if (state == PREAMBLE && mii_txd == 4'h5 && pre_cnt != 4'hF)
        pre_cnt <= pre_cnt + 4'd1;

      if (sfd_ok) begin
        nib_odd  <= 1'b0;
        byte_cnt <= '0;
        crc      <= 32'hFFFFFFFF;
        err      <= 1'b0;
        dl_cnt   <= '0;
        pend_vld <= 1'b0;
      end

      if (state == PAYLOAD && mii_tx_en) begin
        if (mii_tx_er) err <= 1'b1;
        if (!nib_odd) begin
          nib_lo  <= mii_txd;
          nib_odd <= 1'b1;
        end else begin
          nib_odd <= 1'b0;
        end
      end

      // Four bytes of delay hold back the FCS; one more (pend) holds the byte
      // that becomes the tlast beat once tx_en drops.
      if (byte_done) begin
        crc <= crc_byte(crc, byte_in);
        if (byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
        dl <= {dl[2:0], byte_in};
        if (dl_cnt == 3'd4) begin
          pend     <= dl[3];
          pend_vld <= 1'b1;
          if (pend_vld) begin
            m_axis_tdata  <= pend;
            m_axis_tvalid <= 1'b1;
          end
        end else begin
          dl_cnt <= dl_cnt + 3'd1;
        end
      end

      if (eof) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= 1'b1;
        pend_vld      <= 1'b0;
        if (pend_vld) begin
          m_axis_tdata    <= pend;
          m_axis_tuser    <= bad;
          error_bad_frame <= bad;
          error_bad_fcs   <= crc_bad;
        end else begin
          m_axis_tdata    <= 8'h00;
          m_axis_tuser    <= 1'b1;
          error_bad_frame <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mii_tx_sink.sv
// Directed bench for mii_tx_sink: builds MII frames with a reference FCS and
// checks the recovered AXI beats, tlast/tuser and status pulses.
module tb_mii_tx_sink;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] mii_txd = 4'h0;
  logic       mii_tx_en = 1'b0;
  logic       mii_tx_er = 1'b0;
  logic       cfg_enable = 1'b1;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic       error_bad_frame, error_bad_fcs, error_preamble;

  mii_tx_sink #(.MIN_PREAMBLE_NIBBLES(2), .MAX_FRAME_LENGTH(1518)) dut (
    .clk(clk), .rst(rst),
    .mii_txd(mii_txd), .mii_tx_en(mii_tx_en), .mii_tx_er(mii_tx_er),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .cfg_enable(cfg_enable),
    .error_bad_frame(error_bad_frame), .error_bad_fcs(error_bad_fcs),
    .error_preamble(error_preamble)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [7:0] got_d[$];
  int n_last, n_last_user, n_bf, n_bf_last, n_fcs, n_fcs_last, n_pre;

  always @(negedge clk) begin
    if (m_axis_tvalid) begin
      got_d.push_back(m_axis_tdata);
      if (m_axis_tlast) begin
        n_last++;
        if (m_axis_tuser) n_last_user++;
      end
    end
    if (error_bad_frame) begin
      n_bf++;
      if (m_axis_tvalid && m_axis_tlast) n_bf_last++;
    end
    if (error_bad_fcs) begin
      n_fcs++;
      if (m_axis_tvalid && m_axis_tlast) n_fcs_last++;
    end
    if (error_preamble) n_pre++;
  end

  logic [7:0] fb[0:1599];
  int fb_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    got_d.delete();
    n_last = 0; n_last_user = 0; n_bf = 0; n_bf_last = 0;
    n_fcs = 0; n_fcs_last = 0; n_pre = 0;
  endtask

  // Payload of plen bytes, optionally followed by its FCS (LSB first).
  task automatic build(input int plen, input int seed, input bit with_fcs);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < plen; i++) begin
      fb[i] = 8'((seed * 37 + i * 13 + (i >> 3)) & 255);
      c = c ^ {24'h0, fb[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    fb_n = plen;
    if (with_fcs) begin
      c = ~c;
      for (int k = 0; k < 4; k++) fb[plen + k] = c[8*k +: 8];
      fb_n = plen + 4;
    end
  endtask

  task automatic nib(input logic [3:0] n, input logic er);
    @(negedge clk);
    mii_txd = n; mii_tx_en = 1'b1; mii_tx_er = er;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      mii_txd = 4'h0; mii_tx_en = 1'b0; mii_tx_er = 1'b0;
    end
  endtask

  // 15 x 0x5 + 0xD is the 7 x 0x55, 0xD5 preamble/SFD sent low nibble first.
  task automatic send(input int er_idx, input int gap);
    for (int i = 0; i < 15; i++) nib(4'h5, 1'b0);
    nib(4'hD, 1'b0);
    for (int i = 0; i < fb_n; i++) begin
      nib(fb[i][3:0], (i == er_idx));
      nib(fb[i][7:4], 1'b0);
    end
    idle(gap);
  endtask

  task automatic check_frame(input string tag, input int nb, input int nfr, input bit shrt,
                             input bit user, input bit bf, input bit fcs);
    int dm;
    logic [7:0] e;
    dm = 0;
    chk({tag, "_beats"}, got_d.size(), nb * nfr);
    for (int i = 0; i < got_d.size() && i < nb * nfr; i++) begin
      e = shrt ? 8'h00 : fb[i % nb];
      if (got_d[i] !== e) dm++;
    end
    chk({tag, "_data_errs"}, dm, 0);
    chk({tag, "_tlast_cnt"}, n_last, nfr);
    chk({tag, "_tuser_last"}, n_last_user, user ? nfr : 0);
    chk({tag, "_bad_frame"}, n_bf, bf ? nfr : 0);
    chk({tag, "_bad_frame_on_last"}, n_bf_last, bf ? nfr : 0);
    chk({tag, "_bad_fcs"}, n_fcs, fcs ? nfr : 0);
    chk({tag, "_bad_fcs_on_last"}, n_fcs_last, fcs ? nfr : 0);
    chk({tag, "_preamble_err"}, n_pre, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    repeat (3) @(negedge clk);
    chk("reset_outputs", {18'h0, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        error_bad_frame, error_bad_fcs, error_preamble}, 32'h0);
    rst = 1'b0;
    idle(4);

    // Good 64-byte frame
    clr(); build(60, 1, 1'b1); send(-1, 12);
    check_frame("good64", 60, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    // One flipped payload bit
    clr(); build(60, 2, 1'b1); fb[5] = fb[5] ^ 8'h01; send(-1, 12);
    check_frame("bitflip", 60, 1, 1'b0, 1'b1, 1'b1, 1'b1);

    // tx_er mid-payload, CRC still correct
    clr(); build(60, 3, 1'b1); send(10, 12);
    check_frame("tx_er", 60, 1, 1'b0, 1'b1, 1'b1, 1'b0);

    // Malformed preamble, then a good frame after a 1-cycle gap
    clr();
    nib(4'h5, 1'b0); nib(4'h5, 1'b0); nib(4'h7, 1'b0);
    nib(4'h5, 1'b0);
    chk("pre_pulse_on_7", error_preamble, 1'b1);
    for (int i = 0; i < 9; i++) nib(4'h5, 1'b0);
    nib(4'hD, 1'b0);
    for (int i = 0; i < 8; i++) nib(4'(i), 1'b0);
    chk("pre_no_beats", got_d.size(), 0);
    chk("pre_pulse_cnt", n_pre, 1);
    idle(1);
    clr(); build(40, 4, 1'b1); send(-1, 12);
    check_frame("after_pre", 40, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Two frames back-to-back with a 1-cycle gap
    clr(); build(30, 10, 1'b1); send(-1, 1); send(-1, 12);
    check_frame("b2b", 30, 2, 1'b0, 1'b0, 1'b0, 1'b0);

    // Short frame: 3 bytes after SFD
    clr(); build(3, 5, 1'b0); send(-1, 12);
    check_frame("short3", 1, 1, 1'b1, 1'b1, 1'b1, 1'b0);

    // cfg_enable low: frame ignored entirely
    clr(); cfg_enable = 1'b0; build(20, 6, 1'b1); send(-1, 12);
    chk("disabled_beats", got_d.size(), 0);
    chk("disabled_pulses", n_bf + n_fcs + n_pre, 0);
    cfg_enable = 1'b1;

    // 1519 bytes including valid FCS: oversize
    clr(); build(1515, 7, 1'b1); send(-1, 12);
    check_frame("oversize", 1515, 1, 1'b0, 1'b1, 1'b1, 1'b0);

    // Reset mid-payload with tx_en held high
    build(60, 8, 1'b1);
    for (int i = 0; i < 15; i++) nib(4'h5, 1'b0);
    nib(4'hD, 1'b0);
    for (int i = 0; i < 20; i++) begin
      nib(fb[i][3:0], 1'b0);
      nib(fb[i][7:4], 1'b0);
    end
    nib(fb[20][3:0], 1'b0); rst = 1'b1;
    nib(fb[20][7:4], 1'b0);
    clr();
    chk("mid_reset_outputs", {18'h0, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        error_bad_frame, error_bad_fcs, error_preamble}, 32'h0);
    nib(fb[21][3:0], 1'b0); rst = 1'b0;
    nib(fb[21][7:4], 1'b0);
    for (int i = 22; i < fb_n; i++) begin
      nib(fb[i][3:0], 1'b0);
      nib(fb[i][7:4], 1'b0);
    end
    idle(6);
    chk("post_reset_no_beats", got_d.size(), 0);
    chk("post_reset_no_pulses", n_bf + n_fcs + n_pre, 0);
    clr(); build(60, 9, 1'b1); send(-1, 12);
    check_frame("fresh", 60, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mii_tx_sink.md
Name: mii_tx_sink

Overview:
- PHY-side receiver for the MAC's MII transmit interface. Consumes mii_txd/mii_tx_en/mii_tx_er in the MII TX clock domain.
- Strips the preamble, SFD and FCS, packs nibbles into bytes, checks CRC32 and emits each frame as an 8-bit AXI stream with no backpressure.
- Used as a link-partner model and loopback sink, and in board-level PHY emulation.

Parameters:
- MIN_PREAMBLE_NIBBLES, 2: minimum count of 0x5 nibbles that must precede the 0xD SFD nibble.
- MAX_FRAME_LENGTH, 1518: maximum frame length in bytes, including FCS; longer frames are flagged bad.

Ports:
- clk  input  1  MII TX clock, one nibble per cycle.
- rst  input  1  asynchronous active-high reset.
- mii_txd  input  4  transmit nibble, low nibble first.
- mii_tx_en  input  1  transmit enable.
- mii_tx_er  input  1  transmit error.
- m_axis_tdata  output  8  frame byte.
- m_axis_tvalid  output  1  byte valid; there is no tready, so the consumer must always accept.
- m_axis_tlast  output  1  last byte of the frame.
- m_axis_tuser  output  1  bad frame, qualified on the tlast beat.
- cfg_enable  input  1  sampled at frame start; when low, the frame is ignored entirely.
- error_bad_frame  output  1  one-cycle pulse on the tlast beat of a bad frame.
- error_bad_fcs  output  1  one-cycle pulse on the tlast beat when the CRC residue mismatches.
- error_preamble  output  1  one-cycle pulse when preamble or SFD is malformed.

Behaviour:
- Reset:
  - Every output is 0; state is IDLE; the delay line and pending register are empty; CRC = 0xFFFFFFFF.
  - tx_en_prev resets to 1, so a frame already in progress when reset releases is ignored until tx_en falls.
- State machine:
  - IDLE -> PREAMBLE on tx_en=1 with tx_en_prev=0 and cfg_enable=1.
  - If cfg_enable=0 at that point: IDLE -> DISCARD instead.
  - PREAMBLE, nibble 0x5: increment the 5-count, saturating at 15.
  - PREAMBLE, nibble 0xD with count >= MIN_PREAMBLE_NIBBLES: go to PAYLOAD and clear nibble, byte, CRC and error state.
  - PREAMBLE, any other nibble, 0xD too early, tx_er=1, or tx_en falling: pulse error_preamble and go to DISCARD (or IDLE if tx_en=0). No AXI output is produced.
  - PAYLOAD: even nibbles latch the low half; odd nibbles complete the byte as {nibble, low}.
    - Each completed byte updates the CRC (reflected polynomial 0xEDB88320) and the byte count, which is 16-bit saturating.
    - tx_er=1 on any PAYLOAD cycle sets the error flag.
  - PAYLOAD, tx_en=0: end of frame -> IDLE.
  - DISCARD: wait for tx_en=0 -> IDLE.
- FCS strip:
  - Completed bytes enter a 4-byte delay line.
  - Once the line holds 4 bytes, each new byte pushes the oldest byte into a pending register.
  - If pending already held a byte, that byte is driven out the next cycle with tvalid=1, tlast=0, tuser=0.
  - Output beats come at most every other cycle.
- End of frame: the cycle after tx_en falls, pending is driven with tvalid=1, tlast=1 and tuser=bad, where bad is the OR of:
  - tx_er seen;
  - odd nibble count (alignment error);
  - byte count > MAX_FRAME_LENGTH;
  - CRC state != 0xDEBB20E3 after the FCS bytes.
- The status pulses (error_bad_frame, error_bad_fcs) fire on the same cycle as the tlast beat.
- Short frame (pending empty at end, i.e. <=4 bytes after the SFD): emit one beat with tdata=0x00, tvalid=1, tlast=1, tuser=1 and pulse error_bad_frame. Every frame that reached PAYLOAD is closed with exactly one tlast.
- Back-to-back frames: a new SFD may follow with a 1-cycle gap. The end-of-frame beat uses registered pending data, so a new frame's bytes never collide with it; the earliest new-frame byte appears >= 4 bytes later.
- Reset asserted mid-frame: immediate return to reset values. No tlast is emitted for the aborted frame.

Test Plan:
- 64-byte frame (7x 0x55, 0xD5, 60 payload bytes, correct FCS): 60 beats matching the payload, last beat tlast=1, tuser=0, no error pulses.
- Same frame with one payload bit flipped: 60 beats; tlast beat has tuser=1; error_bad_fcs=1 and error_bad_frame=1 for one cycle.
- mii_tx_er=1 for one cycle mid-payload: tlast beat tuser=1, error_bad_frame=1, error_bad_fcs=0.
- Preamble 0x5,0x5,0x7,... : error_preamble pulses on the 0x7 nibble, tvalid stays 0 until tx_en falls. The next good frame after a 1-cycle gap is received correctly.
- 3-byte frame after SFD: a single beat with tdata=0x00, tlast=1, tuser=1 and error_bad_frame=1. A 1519-byte frame with valid FCS: tlast beat tuser=1.
- Reset pulse in the middle of payload with tx_en held high: outputs 0 and no beats until tx_en falls and a fresh frame starts. The fresh frame is received with tuser=0.
